// File: rtl/cpu_control.sv
// cpu_control: multicycle fetch/decode/sequence controller for the 16-bit RISC core.
// Owns PC, IR and the LDR/STR address latch; all control outputs are Moore outputs of state and IR.
module cpu_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mdata,
  input  logic [15:0] datapath_out,
  output logic [7:0]  PC,
  output logic [1:0]  mem_cmd,
  output logic [7:0]  mem_addr,
  output logic [1:0]  vsel,
  output logic        write,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halted
);
  typedef enum logic [4:0] {
    IF1, IF2, UPD_PC, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_C,
    ADDR, LATCH, MEM_RD, LDR_WB, STR_B, STR_C, MEM_WR, HALT
  } state_t;
  state_t state, nxt;
  logic [15:0] ir;
  logic [7:0]  addr_reg;
  logic        unused_hi;
  wire [2:0] opcode = ir[15:13];
  wire [1:0] op     = ir[12:11];
  wire [2:0] rn     = ir[10:8];
  wire [2:0] rd     = ir[7:5];
  wire [1:0] sh     = ir[4:3];
  wire [2:0] rm     = ir[2:0];
  wire is_movi = {opcode, op} == 5'b11010;
  wire is_movr = {opcode, op} == 5'b11000;
  wire is_alu  = opcode == 3'b101;
  wire is_cmp  = is_alu && op == 2'b01;
  wire is_ldr  = {opcode, op} == 5'b01100;
  wire is_str  = {opcode, op} == 5'b10000;
  wire is_halt = {opcode, op} == 5'b11100;
  assign sximm8    = {{8{ir[7]}}, ir[7:0]};
  assign sximm5    = {{11{ir[4]}}, ir[4:0]};
  assign unused_hi = ^datapath_out[15:8];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IF1;
      PC       <= '0;
      ir       <= '0;
      addr_reg <= '0;
    end else begin
      state <= nxt;
      if (state == IF2) ir <= mdata;
      if (state == UPD_PC) PC <= PC + 8'd1;
      if (state == LATCH) addr_reg <= datapath_out[7:0];
    end
  // Outputs are held at zero for the whole time reset is asserted.
  always_comb begin
    nxt      = state;
    mem_cmd  = 2'b00;
    mem_addr = PC;
    vsel     = 2'b00;
    write    = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    shift    = 2'b00;
    halted   = 1'b0;
    if (reset_n)
      case (state)
        IF1:    begin mem_cmd = 2'b01; nxt = IF2; end
        IF2:    begin mem_cmd = 2'b01; nxt = UPD_PC; end
        UPD_PC: nxt = DECODE;
        DECODE: nxt = is_movi ? WR_IMM : is_halt ? HALT :
                      (is_movr || is_alu || is_ldr || is_str) ? GET_A : IF1;
        WR_IMM: begin write = 1'b1; writenum = rn; vsel = 2'b01; nxt = IF1; end
        GET_A:  begin readnum = rn; loada = 1'b1; nxt = (is_ldr || is_str) ? ADDR : GET_B; end
        GET_B:  begin readnum = rm; loadb = 1'b1; nxt = EXEC; end
        EXEC: begin
          shift = sh;
          asel  = is_movr;
          ALUop = is_movr ? 2'b00 : op;
          loads = is_cmp;
          loadc = !is_cmp;
          nxt   = is_cmp ? IF1 : WR_C;
        end
        WR_C:   begin write = 1'b1; writenum = rd; vsel = 2'b11; nxt = IF1; end
        ADDR:   begin bsel = 1'b1; loadc = 1'b1; nxt = LATCH; end
        LATCH:  nxt = is_ldr ? MEM_RD : STR_B;
        MEM_RD: begin mem_cmd = 2'b01; mem_addr = addr_reg; nxt = LDR_WB; end
        LDR_WB: begin mem_cmd = 2'b01; mem_addr = addr_reg; write = 1'b1; writenum = rd; nxt = IF1; end
        STR_B:  begin readnum = rd; loadb = 1'b1; nxt = STR_C; end
        STR_C:  begin asel = 1'b1; loadc = 1'b1; nxt = MEM_WR; end
        MEM_WR: begin mem_cmd = 2'b10; mem_addr = addr_reg; nxt = IF1; end
        HALT:   halted = 1'b1;
        default: nxt = IF1;
      endcase
  end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: scoreboard bench for cpu_control; per-cycle expected control vectors are queued and compared each negedge.
module tb_cpu_control;
  logic        clk, reset_n;
  logic [15:0] mdata, datapath_out;
  logic [7:0]  PC, mem_addr;
  logic [1:0]  mem_cmd, vsel, ALUop, shift;
  logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
  logic [2:0]  writenum, readnum;
  logic [15:0] sximm8, sximm5;
  logic [15:0] mem [256];
  logic [69:0] obs;
  string       tq[$];
  logic [69:0] eq[$], mq[$];
  int          n_chk, n_fail;
  localparam logic [69:0] M  = {{38{1'b1}}, 32'h0};
  localparam logic [69:0] S8 = {38'h0, 16'hFFFF, 16'h0};
  localparam logic [69:0] S5 = {54'h0, 16'hFFFF};

  cpu_control dut (
    .clk(clk), .reset_n(reset_n), .mdata(mdata), .datapath_out(datapath_out),
    .PC(PC), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .vsel(vsel), .write(write),
    .writenum(writenum), .readnum(readnum), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .ALUop(ALUop),
    .shift(shift), .sximm8(sximm8), .sximm5(sximm5), .halted(halted)
  );

  assign obs = {mem_cmd, mem_addr, vsel, write, writenum, readnum, loada, loadb, loadc, loads,
                asel, bsel, ALUop, shift, halted, PC, sximm8, sximm5};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) mdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (tq.size() > 0) begin : pop
      string t;
      logic [69:0] e, m;
      t = tq.pop_front();
      e = eq.pop_front();
      m = mq.pop_front();
      chk(t, obs & m, e & m);
    end

  function automatic logic [69:0] mk(input logic [1:0] mc, input logic [7:0] ma, input logic [1:0] vs,
                                     input logic wr, input logic [2:0] wn, input logic [2:0] rn,
                                     input logic [3:0] ld, input logic as, input logic bs,
                                     input logic [1:0] op, input logic [1:0] sh, input logic h,
                                     input logic [7:0] pc);
    return {mc, ma, vs, wr, wn, rn, ld, as, bs, op, sh, h, pc, 32'h0};
  endfunction

  function automatic logic [69:0] idle(input logic [7:0] pc);
    return mk(0, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc);
  endfunction

  task automatic puti(input string t, input logic [69:0] e, input logic [69:0] m);
    tq.push_back(t);
    eq.push_back(e);
    mq.push_back(m);
  endtask

  task automatic put(input string t, input logic [69:0] e);
    puti(t, e, M);
  endtask

  task automatic fetch(input logic [7:0] p);
    put("if1", mk(1, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, p));
    put("if2", mk(1, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, p));
    put("upd_pc", idle(p));
    put("decode", idle(p + 8'd1));
  endtask

  task automatic ldr_front(input logic [7:0] p);
    logic [7:0] n;
    n = p + 8'd1;
    fetch(p);
    put("ldr_get_a", mk(0, n, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, n));
    puti("ldr_addr", mk(0, n, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0, 0, n) | {54'h0, 16'h0002}, M | S5);
    put("ldr_latch", idle(n));
    put("ldr_mem_rd", mk(1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n));
  endtask

  task automatic drain;
    int g = 0;
    while (tq.size() > 0 && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("drain", 70'(tq.size()), 70'd0);
    tq.delete();
    eq.delete();
    mq.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    datapath_out = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[0] = 16'hD2FD;
    mem[1] = 16'hA160;
    mem[2] = 16'hA900;
    mem[3] = 16'h6182;
    mem[4] = 16'h80BF;
    mem[5] = 16'hE000;
    put("reset", idle(0));
    put("reset", idle(0));
    drain();
    @(posedge clk);
    #1;
    fetch(0);
    puti("mov_wr_imm", mk(0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1) | {38'h0, 16'hFFFD, 16'h0}, M | S8);
    reset_n = 1'b1;
    drain();
    fetch(1);
    put("add_get_a", mk(0, 2, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 2));
    put("add_get_b", mk(0, 2, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 2));
    put("add_exec", mk(0, 2, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 2));
    put("add_wr_c", mk(0, 2, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2));
    fetch(2);
    put("cmp_get_a", mk(0, 3, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 3));
    put("cmp_get_b", mk(0, 3, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 3));
    put("cmp_exec", mk(0, 3, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 3));
    drain();
    datapath_out = 16'h0012;
    ldr_front(3);
    put("ldr_wb", mk(1, 8'h12, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 4));
    drain();
    datapath_out = 16'h0030;
    fetch(4);
    put("str_get_a", mk(0, 5, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 5));
    puti("str_addr", mk(0, 5, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 5) | {54'h0, 16'hFFFF}, M | S5);
    put("str_latch", idle(5));
    put("str_b", mk(0, 5, 0, 0, 0, 5, 4'b0100, 0, 0, 0, 0, 0, 5));
    put("str_c", mk(0, 5, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 0, 0, 5));
    put("str_mem_wr", mk(2, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    fetch(5);
    for (int i = 0; i < 4; i++) put("halt", mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6));
    drain();
    #2 reset_n = 1'b0;
    #1 chk("halt_reset", obs & M, idle(0));
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    @(posedge clk);
    #1;
    fetch(0);
    reset_n = 1'b1;
    drain();
    mem[0] = 16'h6182;
    for (int p = 1; p < 256; p++) fetch(8'(p));
    drain();
    datapath_out = 16'h0012;
    ldr_front(0);
    drain();
    @(posedge clk);
    #1 chk("mid_ldr_wb", obs & M, mk(1, 8'h12, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1));
    #2 reset_n = 1'b0;
    #1 chk("mid_reset", obs & M, idle(0));
    @(posedge clk);
    #1;
    put("refetch", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
